// File: rtl/iobus_ctrl.sv
// I/O bus controller: decodes the CPU I/O address onto NUM_SLOTS peripheral slots
// and runs a registered request/ready handshake. Optional IOBUS_TIMEOUT_EN macro adds an ACCESS timeout.
`ifndef IO_ADDR_WIDTH
`define IO_ADDR_WIDTH 16
`endif
`ifndef IO_DATA_WIDTH
`define IO_DATA_WIDTH 8
`endif

module iobus_ctrl #(
  parameter int IO_ADDR_WIDTH  = `IO_ADDR_WIDTH,
  parameter int IO_DATA_WIDTH  = `IO_DATA_WIDTH,
  parameter int NUM_SLOTS      = 4,
  parameter int BASE_ADDR      = 'h80,
  parameter int SPAN_LOG2      = 7,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           read,
  input  logic                           write,
  input  logic [IO_ADDR_WIDTH-1:0]       addr,
  input  logic [IO_DATA_WIDTH-1:0]       wdata,
  output logic [IO_DATA_WIDTH-1:0]       rdata,
  output logic                           ready,
  output logic                           err,
  output logic [NUM_SLOTS-1:0]           slot_read,
  output logic [NUM_SLOTS-1:0]           slot_write,
  output logic [SPAN_LOG2-1:0]           slot_addr,
  output logic [IO_DATA_WIDTH-1:0]       slot_wdata,
  input  logic [NUM_SLOTS*IO_DATA_WIDTH-1:0] slot_rdata,
  input  logic [NUM_SLOTS-1:0]           slot_ready
);
  localparam int AW    = IO_ADDR_WIDTH;
  localparam int DW    = IO_DATA_WIDTH;
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, RELEASE} state_t;
  state_t state;

  logic [AW-1:0]        off, idx_full;
  logic                 hit;
  logic [IDX_W-1:0]     idx_q;
  logic                 op_rd;
  logic [NUM_SLOTS-1:0] sel_oh;

  assign off      = addr - AW'(BASE_ADDR);
  assign idx_full = off >> SPAN_LOG2;
  assign hit      = (addr >= AW'(BASE_ADDR)) && (idx_full < AW'(NUM_SLOTS));
  assign sel_oh   = NUM_SLOTS'(1) << idx_full[IDX_W-1:0];

`ifdef IOBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rdata      <= '0;
      ready      <= 1'b0;
      err        <= 1'b0;
      slot_read  <= '0;
      slot_write <= '0;
      slot_addr  <= '0;
      slot_wdata <= '0;
      idx_q      <= '0;
      op_rd      <= 1'b0;
`ifdef IOBUS_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (read ^ write) begin
            op_rd      <= read;
            idx_q      <= idx_full[IDX_W-1:0];
            slot_addr  <= off[SPAN_LOG2-1:0];
            slot_wdata <= wdata;
            if (hit) begin
              state      <= ACCESS;
              slot_read  <= read  ? sel_oh : '0;
              slot_write <= write ? sel_oh : '0;
`ifdef IOBUS_TIMEOUT_EN
              cnt        <= '0;
`endif
            end else begin
              state <= DONE;
              ready <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end
          end else if (read && write) begin
            state <= DONE;
            ready <= 1'b1;
            err   <= 1'b1;
            rdata <= '0;
          end
        end
        ACCESS: begin
          // Only the addressed slot can complete; other slot_ready bits are don't-care.
          if (slot_ready[idx_q]) begin
            state      <= DONE;
            ready      <= 1'b1;
            err        <= 1'b0;
            slot_read  <= '0;
            slot_write <= '0;
            if (op_rd) rdata <= slot_rdata[idx_q*DW +: DW];
          end
`ifdef IOBUS_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state      <= DONE;
            ready      <= 1'b1;
            err        <= 1'b1;
            rdata      <= '0;
            slot_read  <= '0;
            slot_write <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          ready <= 1'b0;
          state <= RELEASE;
        end
        RELEASE: begin
          // A level request still held after completion must not re-issue.
          if (!read && !write) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/iobus_ctrl.md
Name: iobus_ctrl

Overview:
Parametrised I/O bus controller and the next generation of the fixed two-slot I/O bus. It sits between the address-space splitter and NUM_SLOTS peripherals. It decodes the I/O address into a one-hot slot select and runs a registered request/ready handshake toward the selected peripheral. Completion is reported to the CPU side with a ready pulse and an error flag, and the controller also covers unmapped addresses and peripherals that never respond.

Parameters:
IO_ADDR_WIDTH, `IO_ADDR_WIDTH, CPU-side I/O address width
IO_DATA_WIDTH, `IO_DATA_WIDTH, data width on both sides
NUM_SLOTS, 4, number of peripheral slots (1..16)
BASE_ADDR, 'h80, address of slot 0
SPAN_LOG2, 7, log2 of bytes per slot; slot-local address width
TIMEOUT_CYCLES, 64, ACCESS cycles allowed before forced error (IOBUS_TIMEOUT_EN only)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
read  in  1  CPU read request, level, held until ready
write  in  1  CPU write request, level, held until ready
addr  in  IO_ADDR_WIDTH  CPU address, stable while request held
wdata  in  IO_DATA_WIDTH  CPU write data
rdata  out  IO_DATA_WIDTH  registered read data, valid with ready
ready  out  1  one-cycle completion pulse
err  out  1  error flag, valid with ready
slot_read  out  NUM_SLOTS  one-hot peripheral read strobe
slot_write  out  NUM_SLOTS  one-hot peripheral write strobe
slot_addr  out  SPAN_LOG2  latched slot-local address
slot_wdata  out  IO_DATA_WIDTH  latched write data
slot_rdata  in  NUM_SLOTS*IO_DATA_WIDTH  flattened peripheral read data; slot i at bits [i*DW +: DW]
slot_ready  in  NUM_SLOTS  per-slot completion

Behaviour:
- Reset (async, rst_n=0): state IDLE. rdata, ready, err, slot_read, slot_write, slot_addr, slot_wdata all 0. Reset mid-transaction aborts it with no ready pulse.
- Decode: off = addr - BASE_ADDR; idx = off >> SPAN_LOG2. Hit iff addr >= BASE_ADDR and idx < NUM_SLOTS. slot_addr = off[SPAN_LOG2-1:0].
- IDLE, read^write=1:
  - Latch op, idx, slot_addr and wdata.
  - Hit -> ACCESS.
  - Miss -> DONE with err=1, rdata=0.
- IDLE, read&write=1: -> DONE with err=1; no slot strobed.
- ACCESS:
  - Exactly one bit of slot_read or slot_write is high, at position idx; held every cycle in ACCESS.
  - When slot_ready[idx]=1: on reads capture slot_rdata[idx] into rdata; err=0; -> DONE; strobes drop.
  - slot_ready bits of other slots are ignored.
- DONE: ready=1 for exactly one cycle, then -> RELEASE.
- RELEASE: wait until read=0 and write=0, then -> IDLE. A held request is never re-issued.
- Latency: a peripheral answering in the first ACCESS cycle gives ready 2 cycles after the request is sampled. A miss or illegal request gives ready 1 cycle after.
- rdata holds its value until the next completed read or error; it is 0 after any error. Writes leave rdata unchanged.
- Request changes during ACCESS are ignored, because all request fields are latched.

Optional Feature:
IOBUS_TIMEOUT_EN.
- Defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES without slot_ready[idx], strobes drop and the FSM goes to DONE with err=1, rdata=0.
  - slot_ready arriving in the same cycle as the timeout wins: normal completion, err=0.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- NUM_SLOTS=4, BASE_ADDR='h80, SPAN_LOG2=7: write addr='h105, wdata='hA5 -> slot_write=4'b0010, slot_addr='h05, slot_wdata='hA5. Slot 1 ready in first ACCESS cycle -> ready 2 cycles after request, err=0.
- Read addr='h180 with slot 2 driving 'h3C and ready after 3 cycles -> slot_read=4'b0100 for 3 cycles, rdata='h3C with ready, err=0.
- Read addr='h40, then addr='h280 (both unmapped) -> no slot strobe; ready 1 cycle after request with err=1, rdata=0.
- read=write=1 -> no strobe, ready with err=1. Request held 5 cycles after ready -> no second ready; a fresh request after release is served normally.
- IOBUS_TIMEOUT_EN, TIMEOUT_CYCLES=64, slot 0 silent -> strobe high 64 cycles, then ready with err=1, rdata=0. Repeat with slot_ready on cycle 64 -> err=0.
- rst_n pulsed low mid-ACCESS -> all outputs 0 immediately, no ready pulse. The next request completes normally.
